// File: rtl/sync_gate_meter.sv
// Measures Sync width, Sync-fall-to-Gate delay, Gate width and frame length of a Sync/Gate stream.
// Latency: results and the valid strobe appear one cycle after the sample showing the next Sync rise.
// No backpressure: ena=0 freezes everything; malformed frames raise err and return to IDLE.
module sync_gate_meter (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        Sync,
  input  logic        Gate,
  output logic [7:0]  m_tsync,
  output logic [7:0]  m_tgdel,
  output logic [15:0] m_tgate,
  output logic [15:0] m_tlen,
  output logic        valid,
  output logic        err
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_SYNC, S_GDEL, S_GATE, S_TAIL} state_t;

  state_t      state_q;
  logic [15:0] seg_q;
  logic [15:0] len_q;
  logic [7:0]  tsync_q;
  logic [7:0]  tgdel_q;
  logic [15:0] tgate_q;
  logic [7:0]  m_tsync_q;
  logic [7:0]  m_tgdel_q;
  logic [15:0] m_tgate_q;
  logic [15:0] m_tlen_q;
  logic        valid_q;
  logic        err_q;

  logic        both_d;
  logic        seg8_max_d;
  logic        seg16_max_d;
  logic        len_max_d;
  logic        fault_d;
  logic        publish_d;
  logic [15:0] seg_inc_d;
  logic [15:0] len_inc_d;

  // Classify the current sample: malformed-frame fault or end-of-frame publish.
  always_comb begin
    both_d      = Sync & Gate;
    seg8_max_d  = (seg_q == 16'd255);
    seg16_max_d = (seg_q == 16'hFFFF);
    len_max_d   = (len_q == 16'hFFFF);
    seg_inc_d   = seg_q + 16'd1;
    len_inc_d   = len_q + 16'd1;
    fault_d     = 1'b0;
    publish_d   = 1'b0;
    case (state_q)
      // Sync still high at 255 would overflow the 8-bit sync field.
      S_SYNC: fault_d = both_d | (Sync & seg8_max_d) | len_max_d;
      // A new Sync before any Gate means the gate never appeared.
      S_GDEL: fault_d = both_d | Sync | (~Gate & seg8_max_d) | len_max_d;
      S_GATE: begin
        fault_d   = both_d | (Gate & seg16_max_d) | (~Sync & len_max_d);
        publish_d = ~Gate & Sync;
      end
      S_TAIL: begin
        fault_d   = both_d | (~Sync & len_max_d);
        publish_d = Sync;
      end
      default: ;
    endcase
  end

  // Frame-tracking FSM with counters, shadows and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      seg_q     <= '0;
      len_q     <= '0;
      tsync_q   <= '0;
      tgdel_q   <= '0;
      tgate_q   <= '0;
      m_tsync_q <= '0;
      m_tgdel_q <= '0;
      m_tgate_q <= '0;
      m_tlen_q  <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (ena) begin
        if (fault_d) begin
          err_q   <= 1'b1;
          seg_q   <= '0;
          len_q   <= '0;
          state_q <= S_IDLE;
        end else if (publish_d) begin
          // A zero-length tail publishes straight from GATE, so the live seg is the gate width.
          m_tsync_q <= tsync_q;
          m_tgdel_q <= tgdel_q;
          m_tgate_q <= (state_q == S_GATE) ? seg_q : tgate_q;
          m_tlen_q  <= len_q;
          valid_q   <= 1'b1;
          // This sample is already the first high cycle of the next sync.
          seg_q     <= 16'd1;
          len_q     <= 16'd1;
          state_q   <= S_SYNC;
        end else begin
          case (state_q)
            S_IDLE: if (!Sync) state_q <= S_ARM;
            S_ARM: begin
              if (Sync && !Gate) begin
                seg_q   <= 16'd1;
                len_q   <= 16'd1;
                state_q <= S_SYNC;
              end
            end
            S_SYNC: begin
              len_q <= len_inc_d;
              if (Sync) begin
                seg_q <= seg_inc_d;
              end else begin
                tsync_q <= seg_q[7:0];
                seg_q   <= 16'd1;
                if (Gate) begin
                  tgdel_q <= '0;
                  state_q <= S_GATE;
                end else begin
                  state_q <= S_GDEL;
                end
              end
            end
            S_GDEL: begin
              len_q <= len_inc_d;
              if (Gate) begin
                tgdel_q <= seg_q[7:0];
                seg_q   <= 16'd1;
                state_q <= S_GATE;
              end else begin
                seg_q <= seg_inc_d;
              end
            end
            S_GATE: begin
              len_q <= len_inc_d;
              if (Gate) begin
                seg_q <= seg_inc_d;
              end else begin
                tgate_q <= seg_q;
                state_q <= S_TAIL;
              end
            end
            S_TAIL:  len_q <= len_inc_d;
            default: state_q <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign m_tsync = m_tsync_q;
  assign m_tgdel = m_tgdel_q;
  assign m_tgate = m_tgate_q;
  assign m_tlen  = m_tlen_q;
  assign valid   = valid_q;
  assign err     = err_q;

endmodule
